// File: rtl/status_led_pkg.sv
// rtl/status_led_pkg.sv - shared mode encoding for the status LED block
package status_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

endpackage

// File: rtl/status_led_prescaler.sv
// rtl/status_led_prescaler.sv - free-running divider producing a one-cycle tick every PRESCALE clocks
module status_led_prescaler #(
  parameter int PRESCALE = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNTW = $clog2(PRESCALE);
  localparam logic [CNTW-1:0] LAST = CNTW'(PRESCALE - 1);

  logic [CNTW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Decoded straight from the count register so tick is low throughout reset.
  assign tick = (count == LAST);

endmodule

// File: rtl/status_led.sv
// rtl/status_led.sv - per-channel LED driver with off/on/blink/breathe modes on a shared timebase
module status_led
  import status_led_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int PRESCALE = 25_000_000,
  parameter  int PWM_BITS = 4,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [1:0]          wr_mode,
  output logic [CHANNELS-1:0] led,
  output logic                tick
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  mode_t               mode [CHANNELS];
  logic                phase;
  logic                dir_down;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [CHANNELS-1:0] led_next;
  logic                breathe;
  logic                wr_hit;

  status_led_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign breathe = (pwm_cnt < duty);
  assign wr_hit  = wr_en && ({1'b0, wr_chan} < (CW + 1)'(CHANNELS));

  always_comb begin
    led_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode[i])
        MODE_OFF:     led_next[i] = 1'b0;
        MODE_ON:      led_next[i] = 1'b1;
        MODE_BLINK:   led_next[i] = phase;
        MODE_BREATHE: led_next[i] = breathe;
        default:      led_next[i] = 1'b0;
      endcase
    end
  end

  // The led register samples pre-edge state, so a mode or tick update shows one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) mode[i] <= MODE_ON;
      led      <= '0;
      phase    <= 1'b0;
      dir_down <= 1'b0;
      duty     <= '0;
      pwm_cnt  <= '0;
    end else begin
      led     <= led_next;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (wr_hit) mode[wr_chan] <= mode_t'(wr_mode);
      if (tick) begin
        phase <= ~phase;
        if (!dir_down) begin
          if (duty == DUTY_MAX) begin
            duty     <= DUTY_MAX - 1'b1;
            dir_down <= 1'b1;
          end else begin
            duty <= duty + 1'b1;
          end
        end else begin
          if (duty == '0) begin
            duty     <= PWM_BITS'(1);
            dir_down <= 1'b0;
          end else begin
            duty <= duty - 1'b1;
          end
        end
      end
    end
  end

endmodule
